mem_access_sequencer: RTL and testbench

- Sits directly upstream of the data-memory port of the load/store path, between the MEM pipeline stage and the 1-cycle-latency synchronous data memory.
- Accepts one load/store request per handshake and splits misaligned halfword/word accesses into two aligned word accesses.
- Merges the returned words, sign/zero-extends load data, and returns a single registered response.
- Holds the pipeline through req_ready while a request is in flight.

---
 rtl/mem_access_sequencer.sv | 277 +++++++++++++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_sequencer
// Purpose  : Load/store sequencer in front of a 1-cycle-latency synchronous
//            data memory. Accepts one request per handshake. Splits misaligned
//            half/word accesses into two aligned word accesses. Merges the
//            returned words and sign/zero-extends load data. Returns one
//            registered response.
// Macro    : MISALIGNED_SPLIT_EN - when defined, misaligned accesses are split
//            into two memory accesses. When undefined, a misaligned access
//            never touches memory and completes with resp_fault=1.
// Ports    : clk, rst_n (async active-low)
//            req_*  : request handshake (valid/ready), we, size, unsigned,
//                     byte address and right-justified store data
//            mem_*  : memory strobe, write enable, word address, byte
//                     strobes, lane-aligned data; rdata/fault return
//            resp_* : response handshake, extended load data, fault
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_word_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_fault,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault
);

    localparam int c_WA_W = ADDR_W - 2;
    localparam logic [c_WA_W-1:0] c_WA_ONE = {{(c_WA_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC0 = 3'd1,
        S_ACC1 = 3'd2,
        S_DONE = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t r_state;

    // Latched request
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_off;

    // Registered outputs
    logic              r_req_ready;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [c_WA_W-1:0] r_mem_word_addr;
    logic [3:0]        r_mem_wstrb;
    logic [31:0]       r_mem_wdata;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_fault;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [1:0] w_req_off;
    logic       w_req_misaligned;
    logic [3:0] w_lane_base;

    assign w_req_off        = req_addr[1:0];
    // Size 2'b11 is treated as a word everywhere, hence req_size[1].
    assign w_req_misaligned = ((req_size == 2'b01) && (w_req_off == 2'd3)) ||
                              (req_size[1] && (w_req_off != 2'd0));

    always_comb begin
        w_lane_base = 4'hF;
        case (req_size)
            2'b00:   w_lane_base = 4'h1;
            2'b01:   w_lane_base = 4'h3;
            default: w_lane_base = 4'hF;
        endcase
    end

`ifdef MISALIGNED_SPLIT_EN
    // The upper nibble/word of these shifted values is what spills into the
    // second access of a split request.
    logic [7:0]  w_lane_mask;
    logic [63:0] w_lane_data;
    assign w_lane_mask = {4'b0000, w_lane_base} << w_req_off;
    assign w_lane_data = {32'd0, req_wdata} << {w_req_off, 3'b000};

    logic        r_split;
    logic [3:0]  r_strb1;
    logic [31:0] r_wdata1;
    logic [31:0] r_word0;
    logic        r_fault0;
`else
    logic [3:0]  w_lane_mask;
    logic [31:0] w_lane_data;
    assign w_lane_mask = w_lane_base << w_req_off;
    assign w_lane_data = req_wdata << {w_req_off, 3'b000};

    logic        r_misalign;
`endif

    // ------------------------------------------------------------------
    // Load assembly, evaluated while in DONE (final word on mem_rdata)
    // ------------------------------------------------------------------
    logic [31:0] w_shifted;
    logic [31:0] w_extended;
    logic        w_fault_all;

`ifdef MISALIGNED_SPLIT_EN
    logic [31:0] w_word_lo;
    logic [31:0] w_word_hi;
    assign w_word_lo   = r_split ? r_word0   : mem_rdata;
    assign w_word_hi   = r_split ? mem_rdata : 32'd0;
    assign w_shifted   = 32'({w_word_hi, w_word_lo} >> {r_off, 3'b000});
    assign w_fault_all = mem_fault | (r_split & r_fault0);
`else
    assign w_shifted   = mem_rdata >> {r_off, 3'b000};
    // A bypassed misaligned request made no access, so its fault is the
    // misalignment itself and mem_rdata/mem_fault are meaningless.
    assign w_fault_all = r_misalign | mem_fault;
`endif

    always_comb begin
        w_extended = w_shifted;
        case (r_size)
            2'b00:   w_extended = {{24{~r_unsigned & w_shifted[7]}},  w_shifted[7:0]};
            2'b01:   w_extended = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default: w_extended = w_shifted;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_we            <= 1'b0;
            r_size          <= 2'b00;
            r_unsigned      <= 1'b0;
            r_off           <= 2'b00;
            r_req_ready     <= 1'b1;
            r_mem_en        <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_word_addr <= '0;
            r_mem_wstrb     <= 4'h0;
            r_mem_wdata     <= 32'd0;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= 32'd0;
            r_resp_fault    <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            r_split         <= 1'b0;
            r_strb1         <= 4'h0;
            r_wdata1        <= 32'd0;
            r_word0         <= 32'd0;
            r_fault0        <= 1'b0;
`else
            r_misalign      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req_ready     <= 1'b0;
                        r_we            <= req_we;
                        r_size          <= req_size;
                        r_unsigned      <= req_unsigned;
                        r_off           <= w_req_off;
                        r_mem_word_addr <= req_addr[ADDR_W-1:2];
                        r_mem_we        <= req_we;
                        r_mem_wstrb     <= req_we ? w_lane_mask[3:0] : 4'h0;
                        r_mem_wdata     <= req_we ? w_lane_data[31:0] : 32'd0;
`ifdef MISALIGNED_SPLIT_EN
                        r_split         <= w_req_misaligned;
                        r_strb1         <= req_we ? w_lane_mask[7:4] : 4'h0;
                        r_wdata1        <= req_we ? w_lane_data[63:32] : 32'd0;
                        r_mem_en        <= 1'b1;
                        r_state         <= S_ACC0;
`else
                        r_misalign      <= w_req_misaligned;
                        r_mem_en        <= ~w_req_misaligned;
                        r_state         <= w_req_misaligned ? S_DONE : S_ACC0;
`endif
                    end
                end

                S_ACC0: begin
`ifdef MISALIGNED_SPLIT_EN
                    if (r_split) begin
                        // Second word address wraps modulo 2^c_WA_W.
                        r_mem_word_addr <= r_mem_word_addr + c_WA_ONE;
                        r_mem_wstrb     <= r_strb1;
                        r_mem_wdata     <= r_wdata1;
                        r_state         <= S_ACC1;
                    end else begin
                        r_mem_en        <= 1'b0;
                        r_mem_we        <= 1'b0;
                        r_mem_wstrb     <= 4'h0;
                        r_mem_wdata     <= 32'd0;
                        r_state         <= S_DONE;
                    end
`else
                    r_mem_en    <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_mem_wstrb <= 4'h0;
                    r_mem_wdata <= 32'd0;
                    r_state     <= S_DONE;
`endif
                end

`ifdef MISALIGNED_SPLIT_EN
                S_ACC1: begin
                    // Result of the first access is on the memory bus now.
                    r_word0     <= mem_rdata;
                    r_fault0    <= mem_fault;
                    r_mem_en    <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_mem_wstrb <= 4'h0;
                    r_mem_wdata <= 32'd0;
                    r_state     <= S_DONE;
                end
`endif

                S_DONE: begin
                    r_resp_valid <= 1'b1;
                    r_resp_fault <= w_fault_all;
                    r_resp_rdata <= (r_we | w_fault_all) ? 32'd0 : w_extended;
                    r_state      <= S_RESP;
                end

                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end

                default: begin
                    r_mem_en     <= 1'b0;
                    r_mem_we     <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign mem_en        = r_mem_en;
    assign mem_we        = r_mem_we;
    assign mem_word_addr = r_mem_word_addr;
    assign mem_wstrb     = r_mem_wstrb;
    assign mem_wdata     = r_mem_wdata;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign resp_fault    = r_resp_fault;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_sequencer
// Purpose  : Self-checking bench for mem_access_sequencer. Directed requests
//            push expected memory accesses and responses into queues; two
//            monitors pop and compare whenever the DUT strobes memory or
//            presents a response. Expectations follow MISALIGNED_SPLIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_sequencer;

    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_ready = 1'b1;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_fault = 1'b0;

    logic        req_ready;
    logic        mem_en;
    logic        mem_we;
    logic [29:0] mem_word_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    mem_access_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_word_addr (mem_word_addr),
        .mem_wstrb     (mem_wstrb),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_fault     (mem_fault),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_fault    (resp_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [29:0] wa;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          acc;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];

    // Memory contents and fault injection, owned by the stimulus process.
    logic [31:0] mem_arr [logic [29:0]];
    bit          fault_en = 1'b0;
    logic [29:0] fault_wa = 30'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // 1-cycle-latency memory; returns a filler pattern when not accessed.
    always @(posedge clk) begin
        if (mem_en) begin
            if (!mem_we && mem_arr.exists(mem_word_addr))
                mem_rdata <= mem_arr[mem_word_addr];
            else
                mem_rdata <= 32'h5A5A5A5A;
            mem_fault <= fault_en && (mem_word_addr == fault_wa);
        end else begin
            mem_rdata <= 32'h5A5A5A5A;
            mem_fault <= 1'b0;
        end
    end

    // Memory-side monitor
    always begin
        acc_t a;
        @(negedge clk);
        #1;
        if (rst_n && mem_en) begin
            if (acc_q.size() == 0) begin
                chk("unexpected_mem_access", 32'(mem_word_addr), 32'hFFFFFFFF);
            end else begin
                a = acc_q.pop_front();
                chk("mem_word_addr", 32'(mem_word_addr), 32'(a.wa));
                chk("mem_we", 32'(mem_we), 32'(a.we));
                chk("mem_wstrb", 32'(mem_wstrb), 32'(a.strb));
                if (a.we) chk("mem_wdata", mem_wdata, a.wdata);
            end
        end
    end

    // Response-side monitor
    rsp_t cur;
    bit   rsp_active = 1'b0;
    always begin
        @(negedge clk);
        #1;
        if (rst_n && resp_valid) begin
            if (!rsp_active) begin
                rsp_active = 1'b1;
                if (rsp_q.size() == 0) begin
                    chk("unexpected_resp", resp_rdata, 32'hFFFFFFFF);
                    cur.rdata = resp_rdata;
                    cur.fault = resp_fault;
                end else begin
                    cur = rsp_q.pop_front();
                    chk("resp_latency", 32'(cyc), 32'(cur.acc + cur.lat));
                    chk("resp_rdata", resp_rdata, cur.rdata);
                    chk("resp_fault", 32'(resp_fault), 32'(cur.fault));
                end
            end else begin
                chk("resp_hold_rdata", resp_rdata, cur.rdata);
                chk("resp_hold_fault", 32'(resp_fault), 32'(cur.fault));
            end
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (resp_ready) rsp_active = 1'b0;
        end
    end

    task automatic exp_acc(input logic [29:0] wa, input logic we, input logic [3:0] strb,
                           input logic [31:0] wd);
        acc_t a;
        a.wa = wa; a.we = we; a.strb = strb; a.wdata = wd;
        acc_q.push_back(a);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        if (!ok) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_rsp, input logic [31:0] exp_rdata,
                          input logic exp_fault, input int lat);
        rsp_t r;
        wait_idle();
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        if (exp_rsp) begin
            r.rdata = exp_rdata; r.fault = exp_fault; r.lat = lat; r.acc = cyc;
            rsp_q.push_back(r);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFC;
        req_wdata = 32'h0BAD_0BAD;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        // Reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_fault", 32'(resp_fault), 32'd0);

        // Aligned word load
        mem_arr[30'h40] = 32'hDEADBEEF;
        exp_acc(30'h40, 1'b0, 4'h0, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 3);

        // Byte loads, signed then unsigned
        wait_idle();
        mem_arr[30'h40] = 32'h80112233;
        exp_acc(30'h40, 1'b0, 4'h0, 32'h0);
        do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0, 3);
        exp_acc(30'h40, 1'b0, 4'h0, 32'h0);
        do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b1, 32'h00000080, 1'b0, 3);

        // Misaligned word store
`ifdef MISALIGNED_SPLIT_EN
        exp_acc(30'h40, 1'b1, 4'b1100, 32'hCCDD0000);
        exp_acc(30'h41, 1'b1, 4'b0011, 32'h0000AABB);
        do_req(1'b1, 2'b10, 1'b0, 32'h102, 32'hAABBCCDD, 1'b1, 32'h0, 1'b0, 4);
`else
        do_req(1'b1, 2'b10, 1'b0, 32'h102, 32'hAABBCCDD, 1'b1, 32'h0, 1'b1, 2);
`endif

        // Misaligned half load across the word-address wrap
        wait_idle();
        mem_arr[30'h3FFFFFFF] = 32'h12345678;
        mem_arr[30'h0]        = 32'hABCDEF34;
`ifdef MISALIGNED_SPLIT_EN
        exp_acc(30'h3FFFFFFF, 1'b0, 4'h0, 32'h0);
        exp_acc(30'h0, 1'b0, 4'h0, 32'h0);
        do_req(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h00003412, 1'b0, 4);
`else
        do_req(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 1'b1, 2);
`endif

        // Aligned byte/half stores
        exp_acc(30'h41, 1'b1, 4'b0010, 32'h0000EE00);
        do_req(1'b1, 2'b00, 1'b0, 32'h105, 32'h000000EE, 1'b1, 32'h0, 1'b0, 3);
        exp_acc(30'h42, 1'b1, 4'b1100, 32'h12340000);
        do_req(1'b1, 2'b01, 1'b0, 32'h10A, 32'h00001234, 1'b1, 32'h0, 1'b0, 3);

        // Half loads at offsets 1, 2 and a negative half at offset 0
        wait_idle();
        mem_arr[30'h42] = 32'h12340000;
        mem_arr[30'h43] = 32'h00008001;
        exp_acc(30'h42, 1'b0, 4'h0, 32'h0);
        do_req(1'b0, 2'b01, 1'b0, 32'h109, 32'h0, 1'b1, 32'h00003400, 1'b0, 3);
        exp_acc(30'h42, 1'b0, 4'h0, 32'h0);
        do_req(1'b0, 2'b01, 1'b1, 32'h10A, 32'h0, 1'b1, 32'h00001234, 1'b0, 3);
        exp_acc(30'h43, 1'b0, 4'h0, 32'h0);
        do_req(1'b0, 2'b01, 1'b0, 32'h10C, 32'h0, 1'b1, 32'hFFFF8001, 1'b0, 3);

        // Aligned load with a fault: data forced to zero
        wait_idle();
        mem_arr[30'hC0] = 32'hCAFEF00D;
        fault_en = 1'b1;
        fault_wa = 30'hC0;
        exp_acc(30'hC0, 1'b0, 4'h0, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b1, 32'h0, 1'b1, 3);

        // Split load, fault on first access only, with response backpressure
        wait_idle();
        mem_arr[30'h80] = 32'h11223344;
        mem_arr[30'h81] = 32'h55667788;
        fault_wa   = 30'h80;
        resp_ready = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
        exp_acc(30'h80, 1'b0, 4'h0, 32'h0);
        exp_acc(30'h81, 1'b0, 4'h0, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h201, 32'h0, 1'b1, 32'h0, 1'b1, 4);
`else
        do_req(1'b0, 2'b10, 1'b0, 32'h201, 32'h0, 1'b1, 32'h0, 1'b1, 2);
`endif
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        if (!seen) chk("bp_resp_timeout", 32'(resp_valid), 32'd1);
        repeat (5) @(negedge clk);
        resp_ready = 1'b1;
        wait_idle();
        fault_en = 1'b0;

        // Illegal size is a word
        exp_acc(30'h40, 1'b0, 4'h0, 32'h0);
        do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b1, 32'h80112233, 1'b0, 3);

        // Misaligned word load at 0x101
        wait_idle();
        mem_arr[30'h41] = 32'h55667788;
`ifdef MISALIGNED_SPLIT_EN
        exp_acc(30'h40, 1'b0, 4'h0, 32'h0);
        exp_acc(30'h41, 1'b0, 4'h0, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1'b1, 32'h88801122, 1'b0, 4);
`else
        do_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1'b1, 32'h0, 1'b1, 2);
`endif

        // Reset during ACC0: access observed, then aborted with no response
        exp_acc(30'h40, 1'b0, 4'h0, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Recovery after the abort
        exp_acc(30'h40, 1'b0, 4'h0, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 32'h80112233, 1'b0, 3);

        wait_idle();
        repeat (3) @(negedge clk);
        chk("pending_responses", 32'(rsp_q.size()), 32'd0);
        chk("pending_accesses", 32'(acc_q.size()), 32'd0);
        chk("resp_still_active", 32'(rsp_active), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
